nor_flash_ctrl: RTL and testbench

Host-side controller that drives the team's `nor_flash_memory` array port (`we`/`re`/`address`/`data_in`, 1-cycle registered `data_out`). It accepts read, program and sector-erase commands over a valid/ready handshake and turns each into a memory access sequence. Programming follows NOR semantics: bits only clear (1→0), and erase sets a whole sector to all-ones.

---
 rtl/nor_flash_pkg.sv | 29 ++
 rtl/nor_flash_ctrl_if.sv | 26 ++
 rtl/nor_flash_memory.sv | 22 ++
 rtl/nor_flash_ctrl.sv | 156 +++++++++++++++
 tb/tb_nor_flash_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash host controller: op encodings, FSM
// states and default geometry.
package nor_flash_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_SECTOR_W = 4;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_PROG    = 2'b01;
  localparam logic [1:0] OP_ERASE   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [DEF_DATA_W-1:0] ERASED_WORD = '1;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    PG_RD,
    PG_CAP,
    PG_WR,
    PG_VRD,
    PG_VCAP,
    ER_WR,
    RESP
  } state_e;

endpackage

// File: rtl/nor_flash_ctrl_if.sv
// Command/response handshake bundle between a host and nor_flash_ctrl.
interface nor_flash_ctrl_if
  import nor_flash_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/nor_flash_memory.sv
// NOR array model: synchronous write, 1-cycle registered read that returns 0
// whenever re is low.
module nor_flash_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[address] <= data_in;
    data_out <= re ? mem_q[address] : '0;
  end

endmodule

// File: rtl/nor_flash_ctrl.sv
// Host-side NOR flash controller: turns read / program / sector-erase commands
// into array access sequences with NOR bit-clear semantics and verify.
module nor_flash_ctrl
  import nor_flash_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SECTOR_W = DEF_SECTOR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  nor_flash_ctrl_if.slave   bus,
  output logic              busy,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   old_q, old_d;
  logic [SECTOR_W-1:0] cnt_q, cnt_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                accept;
  logic [DATA_W-1:0]   and_val;

  // cmd_ready_q is high exactly when the FSM sits in IDLE.
  assign accept  = bus.cmd_valid & cmd_ready_q;
  assign and_val = old_q & wdata_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    old_d       = old_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          cnt_d   = '0;
          case (bus.cmd_op)
            OP_READ:  state_d = RD_REQ;
            OP_PROG:  state_d = PG_RD;
            OP_ERASE: state_d = ER_WR;
            default: begin
              state_d   = RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        state_d     = RESP;
        rsp_rdata_d = mem_rdata;
      end
      PG_RD:  state_d = PG_CAP;
      PG_CAP: begin
        old_d   = mem_rdata;
        state_d = PG_WR;
      end
      PG_WR:  state_d = PG_VRD;
      PG_VRD: state_d = PG_VCAP;
      PG_VCAP: begin
        state_d     = RESP;
        rsp_rdata_d = mem_rdata;
        // Flag both an attempted 0->1 transition and a failed verify.
        rsp_err_d   = (and_val != wdata_q) | (mem_rdata != and_val);
      end
      ER_WR: begin
        if (cnt_q == {SECTOR_W{1'b1}}) state_d = RESP;
        else                           cnt_d   = cnt_q + SECTOR_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    cmd_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    rsp_valid_d   = (state_d == RESP);
    mem_re_d      = (state_d == RD_REQ) || (state_d == PG_RD) || (state_d == PG_VRD);
    mem_we_d      = (state_d == PG_WR) || (state_d == ER_WR);
    mem_address_d = '0;
    mem_wdata_d   = '0;
    if (mem_re_d || (state_d == PG_WR)) mem_address_d = addr_d;
    if (state_d == PG_WR) mem_wdata_d = old_d & wdata_d;
    if (state_d == ER_WR) begin
      mem_address_d = {addr_d[ADDR_W-1:SECTOR_W], cnt_d};
      mem_wdata_d   = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      old_q         <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      old_q         <= old_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;
  assign mem_we        = mem_we_q;
  assign mem_re        = mem_re_q;
  assign mem_address   = mem_address_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Directed bench for nor_flash_ctrl driving a nor_flash_memory array.
module tb_nor_flash_ctrl;
  import nor_flash_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, mem_we, mem_re;
  logic [7:0] mem_address, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int collisions = 0;

  nor_flash_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  nor_flash_ctrl #(.ADDR_W(8), .DATA_W(8), .SECTOR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .mem_we(mem_we), .mem_re(mem_re), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  nor_flash_memory #(.ADDR_W(8), .DATA_W(8)) u_mem (
    .clk(clk), .we(mem_we), .re(mem_re), .address(mem_address),
    .data_in(mem_wdata), .data_out(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(mem_we && mem_re)) else collisions++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command, wait (bounded) for its response and record what the
  // array port did in between.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                         output logic [7:0] rdata, output logic err, output int lat,
                         output int nwe, output int nre, output int hs_bad, output int er_bad);
    int  n;
    bit  got;
    rdata = '0; err = 1'b0; lat = 0; nwe = 0; nre = 0; hs_bad = 0; er_bad = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_wdata = wd;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_wait: got no cmd_ready expected cmd_ready within 50 cycles");
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (mem_we) begin
        if (op == OP_ERASE &&
            (mem_address != {addr[7:4], 4'(nwe)} || mem_wdata != ERASED_WORD)) er_bad++;
        nwe++;
      end
      if (mem_re) nre++;
      if (bus.cmd_ready || !busy) hs_bad++;
      if (bus.rsp_valid) begin
        got = 1'b1; lat = k; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
    int         exp_we;
    int         exp_re;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] rd;
    logic       er;
    int lat, nwe, nre, hs, eb, acc2, bad, nv;
    bit got;

    vecs[0] = '{OP_ERASE,   8'h23, 8'h12, 8'h00, 1'b0, 17, 16, 0};
    vecs[1] = '{OP_READ,    8'h2A, 8'h00, 8'hFF, 1'b0,  3,  0, 1};
    vecs[2] = '{OP_ERASE,   8'h40, 8'h00, 8'h00, 1'b0, 17, 16, 0};
    vecs[3] = '{OP_PROG,    8'h45, 8'hA5, 8'hA5, 1'b0,  6,  1, 2};
    vecs[4] = '{OP_PROG,    8'h45, 8'h21, 8'h21, 1'b0,  6,  1, 2};
    vecs[5] = '{OP_PROG,    8'h45, 8'hFF, 8'h21, 1'b1,  6,  1, 2};
    vecs[6] = '{OP_READ,    8'h45, 8'h00, 8'h21, 1'b0,  3,  0, 1};
    vecs[7] = '{OP_ILLEGAL, 8'h45, 8'h00, 8'h00, 1'b1,  1,  0, 0};
    vecs[8] = '{OP_READ,    8'h2F, 8'h00, 8'hFF, 1'b0,  3,  0, 1};
    vecs[9] = '{OP_READ,    8'h20, 8'h00, 8'hFF, 1'b0,  3,  0, 1};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy, mem_we, mem_re,
         bus.rsp_rdata, mem_address, mem_wdata},
        {1'b1, 5'b0, 24'h0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wd, rd, er, lat, nwe, nre, hs, eb);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), er, vecs[i].exp_err);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_we_cycles", i), nwe, vecs[i].exp_we);
      chk($sformatf("v%0d_re_cycles", i), nre, vecs[i].exp_re);
      chk($sformatf("v%0d_busy_ready", i), hs, 0);
      chk($sformatf("v%0d_erase_addr", i), eb, 0);
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", i), {bus.cmd_ready, busy}, 2'b10);
    end

    // Back-to-back: valid held through a read; second accept at edge 4.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_addr = 8'h2A; bus.cmd_wdata = '0;
    @(posedge clk);
    #1 bus.cmd_addr = 8'h2F;
    acc2 = 0; bad = 0; got = 1'b0; rd = '0;
    for (int k = 1; k <= 10 && acc2 == 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin got = 1'b1; rd = bus.rsp_rdata; end
      if (bus.cmd_ready) acc2 = k;
      else if (!busy) bad++;
    end
    chk("b2b_first_rsp", {got, rd}, {1'b1, 8'hFF});
    chk("b2b_accept_cycle", acc2, 4);
    chk("b2b_busy_c1_3", bad, 0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0; rd = '0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = k; rd = bus.rsp_rdata; end
    end
    chk("b2b_second_latency", lat, 3);
    chk("b2b_second_rdata", rd, 8'hFF);

    // Reset mid-erase: prepare a sector with known non-erased words.
    run_cmd(OP_ERASE, 8'h80, 8'h00, rd, er, lat, nwe, nre, hs, eb);
    chk("pre_erase_latency", lat, 17);
    run_cmd(OP_PROG, 8'h82, 8'h00, rd, er, lat, nwe, nre, hs, eb);
    chk("pre_prog82", {er, rd}, {1'b0, 8'h00});
    run_cmd(OP_PROG, 8'h85, 8'h33, rd, er, lat, nwe, nre, hs, eb);
    chk("pre_prog85", {er, rd}, {1'b0, 8'h33});
    run_cmd(OP_PROG, 8'h86, 8'h5A, rd, er, lat, nwe, nre, hs, eb);
    chk("pre_prog86", {er, rd}, {1'b0, 8'h5A});

    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ERASE; bus.cmd_addr = 8'h8C; bus.cmd_wdata = '0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_erase_c6_strobe", {mem_we, mem_address, mem_wdata}, {1'b1, 8'h85, 8'hFF});
    rst_n = 1'b0;
    #1;
    chk("mid_erase_reset_outputs",
        {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy, mem_we, mem_re,
         bus.rsp_rdata, mem_address, mem_wdata},
        {1'b1, 5'b0, 24'h0});
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid) nv++;
    end
    chk("mid_erase_no_rsp", nv, 0);

    for (int a = 8'h80; a <= 8'h86; a++) begin
      logic [7:0] exp;
      exp = (a == 8'h85) ? 8'h33 : (a == 8'h86) ? 8'h5A : 8'hFF;
      run_cmd(OP_READ, 8'(a), 8'h00, rd, er, lat, nwe, nre, hs, eb);
      chk($sformatf("partial_read_%0h", a), {er, rd}, {1'b0, exp});
    end

    chk("we_re_exclusive", collisions, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
